// File: rtl/mem_access_controller.sv
// Memory-stage access controller for an LC-3b pipeline.
// Sequences one or two data-memory accesses per memory instruction
// (two for LDI/STI), stalls the pipeline while an access is outstanding,
// and squashes the completing instruction when it was flushed mid-access.
module mem_access_controller (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  opcode_mem,
  input  logic        valid_mem,
  input  logic        flush_mem,
  input  logic        d_mem_resp,
  input  logic [15:0] d_mem_rdata,
  input  logic        load_regfile_wb,
  input  logic [2:0]  dest_wb,
  output logic        d_mem_read,
  output logic        d_mem_write,
  output logic        indirectmux_sel,
  output logic [15:0] indirect_addr,
  output logic        save_load_regfile,
  output logic [2:0]  save_dest,
  output logic        stall_pipeline,
  output logic        kill_wb,
  output logic [15:0] stall_count
);

  localparam logic [3:0] OP_LDB = 4'b0010;
  localparam logic [3:0] OP_LDR = 4'b0110;
  localparam logic [3:0] OP_LDI = 4'b1010;
  localparam logic [3:0] OP_STB = 4'b0011;
  localparam logic [3:0] OP_STR = 4'b0111;
  localparam logic [3:0] OP_STI = 4'b1011;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    FIRST  = 2'b01,
    SECOND = 2'b10
  } state_e;

  state_e      state_q, state_d;
  logic        kill_q, kill_d;
  logic [15:0] indirect_addr_q, indirect_addr_d;
  logic        save_load_regfile_q, save_load_regfile_d;
  logic [2:0]  save_dest_q, save_dest_d;
  logic [15:0] stall_count_q, stall_count_d;

  logic is_load, is_store, is_ind, is_mem;
  logic kill_eff;
  logic rd_c, wr_c, sel_c, stall_c, kill_wb_c;

  // Opcode decode of the instruction sitting in MEM.
  always_comb begin
    is_load  = (opcode_mem == OP_LDB) || (opcode_mem == OP_LDR) || (opcode_mem == OP_LDI);
    is_store = (opcode_mem == OP_STB) || (opcode_mem == OP_STR) || (opcode_mem == OP_STI);
    is_ind   = (opcode_mem == OP_LDI) || (opcode_mem == OP_STI);
    is_mem   = is_load || is_store;
    // A flush arriving on the completing cycle itself must still squash.
    kill_eff = kill_q || flush_mem;
  end

  // Next-state, capture and request/stall generation.
  always_comb begin
    state_d             = state_q;
    kill_d              = kill_q;
    indirect_addr_d     = indirect_addr_q;
    save_load_regfile_d = save_load_regfile_q;
    save_dest_d         = save_dest_q;
    rd_c                = 1'b0;
    wr_c                = 1'b0;
    sel_c               = 1'b0;
    stall_c             = 1'b0;
    kill_wb_c           = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (valid_mem && is_mem && !flush_mem) begin
          stall_c = 1'b1;
          state_d = FIRST;
          kill_d  = 1'b0;
        end
      end
      FIRST: begin
        // The first LDI/STI access fetches the pointer, so it is a read.
        rd_c    = is_load || is_ind;
        wr_c    = is_store && !is_ind;
        stall_c = 1'b1;
        kill_d  = kill_eff;
        if (d_mem_resp) begin
          if (is_ind && !kill_eff) begin
            state_d             = SECOND;
            indirect_addr_d     = d_mem_rdata;
            save_load_regfile_d = load_regfile_wb;
            save_dest_d         = dest_wb;
          end else begin
            state_d   = IDLE;
            stall_c   = 1'b0;
            kill_wb_c = kill_eff;
            kill_d    = 1'b0;
          end
        end
      end
      SECOND: begin
        sel_c   = 1'b1;
        rd_c    = (opcode_mem == OP_LDI);
        wr_c    = (opcode_mem == OP_STI);
        stall_c = 1'b1;
        kill_d  = kill_eff;
        if (d_mem_resp) begin
          state_d   = IDLE;
          stall_c   = 1'b0;
          kill_wb_c = kill_eff;
          kill_d    = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        kill_d  = 1'b0;
      end
    endcase
  end

  // Saturating stall-cycle counter.
  always_comb begin
    stall_count_d = stall_count_q;
    if (stall_c && (stall_count_q != 16'hFFFF)) begin
      stall_count_d = stall_count_q + 16'd1;
    end
  end

  // State and capture registers; reset clears everything immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q             <= IDLE;
      kill_q              <= 1'b0;
      indirect_addr_q     <= 16'h0000;
      save_load_regfile_q <= 1'b0;
      save_dest_q         <= 3'b000;
      stall_count_q       <= 16'h0000;
    end else begin
      state_q             <= state_d;
      kill_q              <= kill_d;
      indirect_addr_q     <= indirect_addr_d;
      save_load_regfile_q <= save_load_regfile_d;
      save_dest_q         <= save_dest_d;
      stall_count_q       <= stall_count_d;
    end
  end

  // Control outputs are forced low while reset is held, since the IDLE
  // start condition would otherwise raise stall_pipeline.
  assign d_mem_read        = rd_c && !reset;
  assign d_mem_write       = wr_c && !reset;
  assign indirectmux_sel   = sel_c && !reset;
  assign stall_pipeline    = stall_c && !reset;
  assign kill_wb           = kill_wb_c && !reset;
  assign indirect_addr     = indirect_addr_q;
  assign save_load_regfile = save_load_regfile_q;
  assign save_dest         = save_dest_q;
  assign stall_count       = stall_count_q;

endmodule

// File: tb/tb_mem_access_controller.sv
// Self-checking bench for mem_access_controller: directed scenarios plus
// randomized traffic compared cycle by cycle against a transaction model.
`timescale 1ns/1ps
module tb_mem_access_controller;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  opcode_mem = 4'h0;
  logic        valid_mem = 1'b0;
  logic        flush_mem = 1'b0;
  logic        d_mem_resp = 1'b0;
  logic [15:0] d_mem_rdata = 16'h0;
  logic        load_regfile_wb = 1'b0;
  logic [2:0]  dest_wb = 3'd0;
  logic        d_mem_read, d_mem_write, indirectmux_sel;
  logic [15:0] indirect_addr;
  logic        save_load_regfile;
  logic [2:0]  save_dest;
  logic        stall_pipeline, kill_wb;
  logic [15:0] stall_count;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [3:0] LDB = 4'b0010, LDR = 4'b0110, LDI = 4'b1010;
  localparam logic [3:0] STB = 4'b0011, STR = 4'b0111, STI = 4'b1011;

  mem_access_controller dut (
    .clk(clk), .reset(reset), .opcode_mem(opcode_mem), .valid_mem(valid_mem),
    .flush_mem(flush_mem), .d_mem_resp(d_mem_resp), .d_mem_rdata(d_mem_rdata),
    .load_regfile_wb(load_regfile_wb), .dest_wb(dest_wb),
    .d_mem_read(d_mem_read), .d_mem_write(d_mem_write),
    .indirectmux_sel(indirectmux_sel), .indirect_addr(indirect_addr),
    .save_load_regfile(save_load_regfile), .save_dest(save_dest),
    .stall_pipeline(stall_pipeline), .kill_wb(kill_wb), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  // Transaction model: an instruction in flight, how many of its accesses
  // have completed, and whether it has been squashed.
  bit          m_busy = 0;
  int          m_done = 0;
  bit          m_kill = 0;
  logic [15:0] m_addr = 16'h0;
  logic        m_sl = 1'b0;
  logic [2:0]  m_sd = 3'd0;
  int          m_cnt = 0;

  function automatic bit f_load(input logic [3:0] op);
    return op == LDB || op == LDR || op == LDI;
  endfunction
  function automatic bit f_store(input logic [3:0] op);
    return op == STB || op == STR || op == STI;
  endfunction
  function automatic bit f_ind(input logic [3:0] op);
    return op == LDI || op == STI;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // One clock cycle: apply inputs after the falling edge, check outputs,
  // then advance the model to what the next rising edge should produce.
  task automatic step(input bit rs, input logic [3:0] op, input logic v, input logic f,
                      input logic r, input logic [15:0] rd, input logic lw, input logic [2:0] dw);
    bit e_rd, e_wr, e_sel, e_st, e_kl, k, last;
    int need;
    @(negedge clk);
    reset = rs; opcode_mem = op; valid_mem = v; flush_mem = f;
    d_mem_resp = r; d_mem_rdata = rd; load_regfile_wb = lw; dest_wb = dw;
    #1;
    e_rd = 0; e_wr = 0; e_sel = 0; e_st = 0; e_kl = 0; k = 0; last = 0; need = 1;
    if (rs) begin
      m_busy = 0; m_done = 0; m_kill = 0; m_addr = 16'h0; m_sl = 0; m_sd = 3'd0; m_cnt = 0;
    end else if (!m_busy) begin
      e_st = v && (f_load(op) || f_store(op)) && !f;
    end else begin
      k    = m_kill || f;
      need = (f_ind(op) && !k) ? 2 : 1;
      e_sel = (m_done == 1);
      if (m_done == 0) begin
        e_rd = f_load(op) || f_ind(op);
        e_wr = !e_rd;
      end else begin
        e_rd = (op == LDI);
        e_wr = (op == STI);
      end
      last = r && (m_done + 1 >= need);
      e_st = !last;
      e_kl = last && k;
    end
    chk("d_mem_read", d_mem_read, e_rd);
    chk("d_mem_write", d_mem_write, e_wr);
    chk("rd_wr_excl", d_mem_read & d_mem_write, 0);
    chk("indirectmux_sel", indirectmux_sel, e_sel);
    chk("stall_pipeline", stall_pipeline, e_st);
    chk("kill_wb", kill_wb, e_kl);
    chk("indirect_addr", indirect_addr, m_addr);
    chk("save_load_regfile", save_load_regfile, m_sl);
    chk("save_dest", save_dest, m_sd);
    chk("stall_count", stall_count, m_cnt);
    if (!rs) begin
      if (e_st && m_cnt < 65535) m_cnt++;
      if (!m_busy) begin
        if (e_st) begin m_busy = 1; m_done = 0; m_kill = 0; end
      end else begin
        m_kill = k;
        if (r) begin
          if (last) begin
            m_busy = 0; m_done = 0; m_kill = 0;
          end else begin
            m_done = 1; m_addr = rd; m_sl = lw; m_sd = dw;
          end
        end
      end
    end
  endtask

  task automatic idle_step();
    step(0, 4'h0, 0, 0, 0, 16'h0, 0, 3'd0);
  endtask

  task automatic do_reset();
    // A valid LDR is presented while reset is high: nothing may start.
    step(1, LDR, 1, 0, 1, 16'hBEEF, 1, 3'd7);
    step(1, LDR, 1, 0, 0, 16'h0, 0, 3'd0);
  endtask

  initial begin
    logic [3:0] ops [6];
    logic [3:0] cur_op;
    logic       cur_v;
    ops[0] = LDB; ops[1] = LDR; ops[2] = LDI; ops[3] = STB; ops[4] = STR; ops[5] = STI;

    // Reset state.
    do_reset();

    // LDR: three waiting cycles then response; four stall cycles in total.
    step(0, LDR, 1, 0, 0, 16'h0, 0, 3'd0);
    step(0, LDR, 1, 0, 0, 16'h0, 0, 3'd0);
    step(0, LDR, 1, 0, 0, 16'h0, 0, 3'd0);
    step(0, LDR, 1, 0, 0, 16'h0, 0, 3'd0);
    step(0, LDR, 1, 0, 1, 16'h1234, 0, 3'd0);
    idle_step();
    chk("ldr_stall_count", stall_count, 16'd4);

    // LDI: pointer 0x3000 with WB forwarding state captured on first response.
    do_reset();
    step(0, LDI, 1, 0, 0, 16'h0, 0, 3'd0);
    step(0, LDI, 1, 0, 1, 16'h3000, 1, 3'd5);
    step(0, LDI, 1, 0, 0, 16'h0, 0, 3'd1);
    step(0, LDI, 1, 0, 1, 16'h5555, 0, 3'd2);
    idle_step();
    chk("ldi_indirect_addr", indirect_addr, 16'h3000);
    chk("ldi_save_dest", save_dest, 3'd5);
    chk("ldi_save_load", save_load_regfile, 1);

    // STI: read pointer, then write.
    step(0, STI, 1, 0, 0, 16'h0, 0, 3'd0);
    step(0, STI, 1, 0, 1, 16'h4242, 0, 3'd3);
    step(0, STI, 1, 0, 0, 16'h0, 1, 3'd0);
    step(0, STI, 1, 0, 1, 16'h0, 0, 3'd0);
    idle_step();

    // STR flushed while waiting: write still completes, then squashed.
    step(0, STR, 1, 0, 0, 16'h0, 0, 3'd0);
    step(0, STR, 1, 1, 0, 16'h0, 0, 3'd0);
    step(0, STR, 1, 0, 0, 16'h0, 0, 3'd0);
    step(0, STR, 1, 0, 1, 16'h0, 0, 3'd0);
    chk("str_back_idle", stall_pipeline, 0);
    idle_step();

    // Flushed LDI: skips the second access.
    step(0, LDI, 1, 0, 0, 16'h0, 0, 3'd0);
    step(0, LDI, 1, 1, 1, 16'h7777, 1, 3'd6);
    idle_step();

    // Flush in IDLE suppresses start; response in IDLE is ignored.
    step(0, LDB, 1, 1, 0, 16'h0, 0, 3'd0);
    step(0, 4'h1, 1, 0, 1, 16'h9999, 1, 3'd4);

    // LDI reset during the second access.
    step(0, LDI, 1, 0, 0, 16'h0, 0, 3'd0);
    step(0, LDI, 1, 0, 1, 16'hABCD, 1, 3'd3);
    step(0, LDI, 1, 0, 0, 16'h0, 0, 3'd0);
    step(1, LDI, 1, 0, 0, 16'h0, 0, 3'd0);
    chk("rst_indirect_addr", indirect_addr, 16'h0000);
    chk("rst_mux_sel", indirectmux_sel, 0);
    step(0, 4'h0, 0, 0, 1, 16'h0, 0, 3'd0);

    // Saturation: hold a load without response for 70000 cycles.
    do_reset();
    step(0, LDR, 1, 0, 0, 16'h0, 0, 3'd0);
    step(0, LDR, 1, 0, 0, 16'h0, 0, 3'd0);
    repeat (70000) @(posedge clk);
    m_cnt = 65535;
    chk("sat_count", stall_count, 16'hFFFF);
    step(0, LDR, 1, 0, 0, 16'h0, 0, 3'd0);
    step(0, LDR, 1, 0, 1, 16'h0, 0, 3'd0);
    idle_step();

    // Randomized traffic; the MEM instruction is held while it is stalled.
    do_reset();
    cur_op = 4'h0; cur_v = 0;
    for (int i = 0; i < 3000; i++) begin
      if (!m_busy) begin
        cur_op = ($urandom_range(0, 9) < 7) ? ops[$urandom_range(0, 5)] : 4'($urandom_range(0, 15));
        cur_v  = ($urandom_range(0, 9) < 8);
      end
      step(0, cur_op, cur_v, ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) < 4),
           16'($urandom), 1'($urandom), 3'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
